// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM configuration sequencer: register map,
// sequencer state encoding and the order in which registers are written.
package pwm_pkg;

    localparam logic [3:0] ADDR_CTRL     = 4'h0;
    localparam logic [3:0] ADDR_PERIOD   = 4'h4;
    localparam logic [3:0] ADDR_DUTY1    = 4'h8;
    localparam logic [3:0] ADDR_DUTY2    = 4'hC;
    localparam logic [3:0] ADDR_DEADTIME = 4'hD;
    localparam logic [3:0] ADDR_PRESC    = 4'hE;

    localparam logic [2:0] LAST_WR_IDX = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_WAIT_EVT,
        S_WRITE,
        S_DONE
    } seq_state_t;

    // Prescaler goes first so the new period is counted with the new tick rate.
    function automatic logic [3:0] wr_order_addr(input logic [2:0] idx);
        case (idx)
            3'd0:    wr_order_addr = ADDR_PRESC;
            3'd1:    wr_order_addr = ADDR_PERIOD;
            3'd2:    wr_order_addr = ADDR_DUTY1;
            3'd3:    wr_order_addr = ADDR_DUTY2;
            default: wr_order_addr = ADDR_DEADTIME;
        endcase
    endfunction

endpackage

// File: rtl/pwm_seq_timer.sv
// Loadable up-counter with terminal-count flag, used to bound the wait for
// the PWM period-boundary event. Holds at terminal count.
module pwm_seq_timer #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] count;

    assign tc = (count == CW'(TIMEOUT_CYC - 1));

    // Count register: load clears, enable advances until terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_cfg_sequencer.sv
// Atomic PWM register-block reconfiguration sequencer.
// Optional feature macro: PWM_SEQ_READBACK_EN (read back and verify each write).
module pwm_cfg_sequencer
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sync_en,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_duty1,
    input  logic [WIDTH-1:0] cfg_duty2,
    input  logic [WIDTH-1:0] cfg_deadtime,
    input  logic [WIDTH-1:0] cfg_prescaler,
    input  logic             upd_evt,
    output logic             reg_wr_en,
    output logic             reg_rd_en,
    output logic [3:0]       reg_addr,
    output logic [WIDTH-1:0] reg_wr_data,
    input  logic [WIDTH-1:0] reg_rd_data,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic             err_clamp
`ifdef PWM_SEQ_READBACK_EN
    ,
    output logic             err_readback
`endif
);

    seq_state_t       state, state_next;
    logic [2:0]       idx;
    logic             sync_q;
    logic             start_acc;
    logic             tmr_tc;
    logic             advance;
    logic [WIDTH-1:0] sh_period, sh_duty1, sh_duty2, sh_deadtime, sh_presc;
    logic [WIDTH-1:0] shadow_sel;
    logic             err_timeout_q, err_clamp_q;

`ifdef PWM_SEQ_READBACK_EN
    logic rd_phase;
    logic err_readback_q;
    assign advance      = rd_phase;
    assign err_readback = err_readback_q;
`else
    logic rd_phase;
    logic unused_rd_data;
    assign rd_phase       = 1'b0;
    assign advance        = 1'b1;
    assign unused_rd_data = ^reg_rd_data;
`endif

    assign start_acc = (state == S_IDLE) && start;

    // Timer runs from the latch cycle so the wait window closes TIMEOUT_CYC
    // cycles after the latch cycle begins.
    pwm_seq_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_acc),
        .en    ((state == S_LATCH) || (state == S_WAIT_EVT)),
        .tc    (tmr_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic and Moore outputs.
    always_comb begin
        state_next  = state;
        busy        = (state != S_IDLE);
        done        = (state == S_DONE);
        reg_wr_en   = 1'b0;
        reg_rd_en   = 1'b0;
        reg_addr    = '0;
        reg_wr_data = '0;
        case (state)
            S_IDLE:     if (start) state_next = S_LATCH;
            S_LATCH:    state_next = sync_q ? S_WAIT_EVT : S_WRITE;
            S_WAIT_EVT: begin
                if (upd_evt)     state_next = S_WRITE;
                else if (tmr_tc) state_next = S_IDLE;
            end
            S_WRITE: begin
                reg_wr_en   = !rd_phase;
                reg_rd_en   = rd_phase;
                reg_addr    = wr_order_addr(idx);
                reg_wr_data = shadow_sel;
                if (advance && (idx == LAST_WR_IDX)) state_next = S_DONE;
            end
            S_DONE:     state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Shadow value matching the current write index.
    always_comb begin
        case (idx)
            3'd0:    shadow_sel = sh_presc;
            3'd1:    shadow_sel = sh_period;
            3'd2:    shadow_sel = sh_duty1;
            3'd3:    shadow_sel = sh_duty2;
            default: shadow_sel = sh_deadtime;
        endcase
    end

    // Shadow capture with duty clamping, sticky error flags, write index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= 1'b0;
            sh_period     <= '0;
            sh_duty1      <= '0;
            sh_duty2      <= '0;
            sh_deadtime   <= '0;
            sh_presc      <= '0;
            err_timeout_q <= 1'b0;
            err_clamp_q   <= 1'b0;
            idx           <= '0;
        end else begin
            if (start_acc) begin
                sync_q        <= sync_en;
                err_timeout_q <= 1'b0;
                err_clamp_q   <= 1'b0;
            end
            if (state == S_LATCH) begin
                sh_period   <= cfg_period;
                sh_deadtime <= cfg_deadtime;
                sh_presc    <= cfg_prescaler;
                sh_duty1    <= (cfg_duty1 > cfg_period) ? cfg_period : cfg_duty1;
                sh_duty2    <= (cfg_duty2 > cfg_period) ? cfg_period : cfg_duty2;
                if ((cfg_duty1 > cfg_period) || (cfg_duty2 > cfg_period))
                    err_clamp_q <= 1'b1;
            end
            if ((state == S_WAIT_EVT) && !upd_evt && tmr_tc)
                err_timeout_q <= 1'b1;
            if (state != S_WRITE) idx <= '0;
            else if (advance)     idx <= idx + 3'd1;
        end
    end

`ifdef PWM_SEQ_READBACK_EN
    // Alternate write/read beats and flag any readback mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_phase       <= 1'b0;
            err_readback_q <= 1'b0;
        end else begin
            rd_phase <= (state == S_WRITE) ? !rd_phase : 1'b0;
            if (start_acc)
                err_readback_q <= 1'b0;
            else if ((state == S_WRITE) && rd_phase && (reg_rd_data != shadow_sel))
                err_readback_q <= 1'b1;
        end
    end
`endif

    assign err_timeout = err_timeout_q;
    assign err_clamp   = err_clamp_q;

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Self-checking bench for pwm_cfg_sequencer (also covers PWM_SEQ_READBACK_EN builds).
module tb_pwm_cfg_sequencer;

    localparam int unsigned W = 16;
`ifdef PWM_SEQ_READBACK_EN
    localparam int unsigned STRIDE = 2;
`else
    localparam int unsigned STRIDE = 1;
`endif
    localparam int unsigned DONE_OFS = 2 + 5 * STRIDE;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sync_en = 1'b0, upd_evt = 1'b0;
    logic [W-1:0] cfg_period = '0, cfg_duty1 = '0, cfg_duty2 = '0;
    logic [W-1:0] cfg_deadtime = '0, cfg_prescaler = '0;
    logic [W-1:0] reg_rd_data;
    logic corrupt = 1'b0;

    logic a_wr_en, a_rd_en, a_busy, a_done, a_err_t, a_err_c;
    logic [3:0] a_addr;
    logic [W-1:0] a_wr_data;
    logic b_wr_en, b_rd_en, b_busy, b_done, b_err_t, b_err_c;
    logic [3:0] b_addr;
    logic [W-1:0] b_wr_data;
`ifdef PWM_SEQ_READBACK_EN
    logic a_err_rb, b_err_rb;
`endif

    always #5 clk = ~clk;

    pwm_cfg_sequencer #(.WIDTH(W), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sync_en(sync_en),
        .cfg_period(cfg_period), .cfg_duty1(cfg_duty1), .cfg_duty2(cfg_duty2),
        .cfg_deadtime(cfg_deadtime), .cfg_prescaler(cfg_prescaler), .upd_evt(upd_evt),
        .reg_wr_en(a_wr_en), .reg_rd_en(a_rd_en), .reg_addr(a_addr), .reg_wr_data(a_wr_data),
        .reg_rd_data(reg_rd_data), .busy(a_busy), .done(a_done),
        .err_timeout(a_err_t), .err_clamp(a_err_c)
`ifdef PWM_SEQ_READBACK_EN
        , .err_readback(a_err_rb)
`endif
    );

    pwm_cfg_sequencer #(.WIDTH(W), .TIMEOUT_CYC(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .sync_en(sync_en),
        .cfg_period(cfg_period), .cfg_duty1(cfg_duty1), .cfg_duty2(cfg_duty2),
        .cfg_deadtime(cfg_deadtime), .cfg_prescaler(cfg_prescaler), .upd_evt(upd_evt),
        .reg_wr_en(b_wr_en), .reg_rd_en(b_rd_en), .reg_addr(b_addr), .reg_wr_data(b_wr_data),
        .reg_rd_data(reg_rd_data), .busy(b_busy), .done(b_done),
        .err_timeout(b_err_t), .err_clamp(b_err_c)
`ifdef PWM_SEQ_READBACK_EN
        , .err_readback(b_err_rb)
`endif
    );

    // Register-block model: reads return what was written, optionally corrupting DUTY2.
    always_comb begin
        reg_rd_data = a_wr_data;
        if (corrupt && (a_addr == 4'hC)) reg_rd_data = ~a_wr_data;
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned c;
        logic [3:0]  a;
        logic [W-1:0] d;
    } wr_t;

    wr_t wlog[$];
    int unsigned dlog[$], blog[$], t_err[$], t_wr[$], t_done[$];
    logic b_err_d = 1'b0;

    // Event logs sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_wr_en) begin
                wr_t e;
                e.c = cyc; e.a = a_addr; e.d = a_wr_data;
                wlog.push_back(e);
            end
            if (a_done) dlog.push_back(cyc);
            if (a_busy) blog.push_back(cyc);
            if (b_err_t && !b_err_d) t_err.push_back(cyc);
            if (b_wr_en) t_wr.push_back(cyc);
            if (b_done) t_done.push_back(cyc);
        end
        b_err_d = b_err_t;
    end

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] presc, period, d1, d2, dt;
        logic [W-1:0] e [5];
        logic         clamp;
    } vec_t;

    vec_t vt [4];
    logic [3:0] exp_addr [5];
    int unsigned wb, db, bb, tb0, tw0, td0;

    task automatic set_cfg(input vec_t v);
        cfg_prescaler = v.presc; cfg_period = v.period;
        cfg_duty1 = v.d1; cfg_duty2 = v.d2; cfg_deadtime = v.dt;
    endtask

    task automatic launch(input logic sync, output int unsigned t0);
        @(posedge clk); #1;
        wb = wlog.size(); db = dlog.size(); bb = blog.size();
        tb0 = t_err.size(); tw0 = t_wr.size(); td0 = t_done.size();
        start = 1'b1; sync_en = sync; t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic goto_cycle(input int unsigned t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
    endtask

    // Check the five writes, done pulse and busy window of one sequence.
    task automatic check_seq(input string tag, input int unsigned first_wr,
                             input int unsigned t0, input logic [W-1:0] e [5]);
        chk({tag, " nwr"}, wlog.size() - wb, 5);
        for (int unsigned k = 0; k < 5; k++) begin
            if (wb + k < wlog.size()) begin
                chk({tag, " addr"}, wlog[wb + k].a, exp_addr[k]);
                chk({tag, " data"}, wlog[wb + k].d, e[k]);
                chk({tag, " wcyc"}, wlog[wb + k].c - t0, first_wr + k * STRIDE);
            end
        end
        chk({tag, " ndone"}, dlog.size() - db, 1);
        if (dlog.size() > db) chk({tag, " dcyc"}, dlog[db] - t0, first_wr + 5 * STRIDE);
        chk({tag, " nbusy"}, blog.size() - bb, first_wr + 5 * STRIDE);
        if (blog.size() > bb) chk({tag, " bfirst"}, blog[bb] - t0, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " wr_en"}, a_wr_en, 0);
        chk({tag, " rd_en"}, a_rd_en, 0);
        chk({tag, " addr"}, a_addr, 0);
        chk({tag, " wdata"}, a_wr_data, 0);
        chk({tag, " busy"}, a_busy, 0);
        chk({tag, " done"}, a_done, 0);
        chk({tag, " err_t"}, a_err_t, 0);
        chk({tag, " err_c"}, a_err_c, 0);
    endtask

    initial begin
        int unsigned t0;
        exp_addr = '{4'hE, 4'h4, 4'h8, 4'hC, 4'hD};
        vt[0] = '{presc: 16'd3,    period: 16'd100,  d1: 16'd40,     d2: 16'd60,     dt: 16'd5,
                  e: '{16'd3, 16'd100, 16'd40, 16'd60, 16'd5},         clamp: 1'b0};
        vt[1] = '{presc: 16'd7,    period: 16'd100,  d1: 16'd200,    d2: 16'd60,     dt: 16'd2,
                  e: '{16'd7, 16'd100, 16'd100, 16'd60, 16'd2},        clamp: 1'b1};
        vt[2] = '{presc: 16'h0000, period: 16'h1234, d1: 16'h1234,   d2: 16'h1235,   dt: 16'hFFFF,
                  e: '{16'h0000, 16'h1234, 16'h1234, 16'h1234, 16'hFFFF}, clamp: 1'b1};
        vt[3] = '{presc: 16'hFFFF, period: 16'hFFFF, d1: 16'h0000,   d2: 16'hFFFF,   dt: 16'h0000,
                  e: '{16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000}, clamp: 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Table: immediate (sync_en=0) sequences, clamp set and cleared.
        for (int unsigned i = 0; i < 4; i++) begin
            set_cfg(vt[i]);
            launch(1'b0, t0);
            goto_cycle(t0 + DONE_OFS + 3);
            check_seq($sformatf("vec%0d", i), 2, t0, vt[i].e);
            chk($sformatf("vec%0d clamp", i), a_err_c, vt[i].clamp);
            chk($sformatf("vec%0d err_t", i), a_err_t, 0);
        end

        // Synchronised: event at T+20, first write T+21.
        set_cfg(vt[0]);
        launch(1'b1, t0);
        goto_cycle(t0 + 20);
        upd_evt = 1'b1;
        @(posedge clk); #1;
        upd_evt = 1'b0;
        goto_cycle(t0 + 21 + 5 * STRIDE + 3);
        check_seq("sync20", 21, t0, vt[0].e);

        // Event during the latch cycle is ignored; only the later one counts.
        launch(1'b1, t0);
        upd_evt = 1'b1;
        @(posedge clk); #1;
        upd_evt = 1'b0;
        goto_cycle(t0 + 10);
        upd_evt = 1'b1;
        @(posedge clk); #1;
        upd_evt = 1'b0;
        goto_cycle(t0 + 11 + 5 * STRIDE + 3);
        check_seq("latchevt", 11, t0, vt[0].e);

        // Timeout on the TIMEOUT_CYC=16 instance.
        launch(1'b1, t0);
        goto_cycle(t0 + 16);
        chk("to16 busy@16", b_busy, 1);
        chk("to16 err@16", b_err_t, 0);
        goto_cycle(t0 + 17);
        chk("to16 busy@17", b_busy, 0);
        chk("to16 err@17", b_err_t, 1);
        goto_cycle(t0 + 80);
        chk("to16 nerr", t_err.size() - tb0, 1);
        if (t_err.size() > tb0) chk("to16 errcyc", t_err[tb0] - t0, 17);
        chk("to16 nwr", t_wr.size() - tw0, 0);
        chk("to16 ndone", t_done.size() - td0, 0);
        chk("to64 err", a_err_t, 1);
        chk("to64 nwr", wlog.size() - wb, 0);
        launch(1'b0, t0);
        chk("to16 cleared", b_err_t, 0);
        goto_cycle(t0 + DONE_OFS + 3);
        check_seq("after_to", 2, t0, vt[0].e);

        // Starts while busy and in the done cycle are dropped.
        launch(1'b0, t0);
        goto_cycle(t0 + 3); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        goto_cycle(t0 + 5); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        goto_cycle(t0 + DONE_OFS); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        goto_cycle(t0 + DONE_OFS + 10);
        check_seq("drop", 2, t0, vt[0].e);

        // Reset asserted during the third write cycle aborts the sequence.
        launch(1'b0, t0);
        goto_cycle(t0 + 3); start = 1'b1;
        goto_cycle(t0 + 4); start = 1'b0;
        rst_n = 1'b0;
        #2;
        check_idle_outputs("midrst");
        chk("midrst nwr", wlog.size() - wb, (STRIDE == 1) ? 2 : 1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wb = wlog.size(); db = dlog.size();
        repeat (20) @(posedge clk);
        #1;
        chk("postrst nwr", wlog.size() - wb, 0);
        chk("postrst ndone", dlog.size() - db, 0);
        check_idle_outputs("postrst");

`ifdef PWM_SEQ_READBACK_EN
        // Corrupted DUTY2 readback flags the error but the sequence completes.
        corrupt = 1'b1;
        launch(1'b0, t0);
        goto_cycle(t0 + DONE_OFS + 3);
        corrupt = 1'b0;
        check_seq("rb", 2, t0, vt[0].e);
        chk("rb err", a_err_rb, 1);
        launch(1'b0, t0);
        goto_cycle(t0 + DONE_OFS + 3);
        chk("rb cleared", a_err_rb, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
